// File: rtl/nibble_serial_adder32.sv
// nibble_serial_adder32
//   32-bit adder that processes one 4-bit nibble per clock: 8 RUN cycles per
//   operation, least-significant nibble first, carry rippled through a
//   register between nibbles.
//
//   Optional feature macro: SUB_EN
//     defined   -> port Sub exists; Sub=1 computes X - Y (Cin ignored,
//                  Cout=1 means no borrow)
//     undefined -> add-only, no Sub port
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   begin an operation (accepted in IDLE or DONE)
//   X, Y   in   32-bit operands, latched on acceptance
//   Cin    in   carry into bit 0, latched on acceptance
//   Sub    in   subtract select (SUB_EN only)
//   F      out  result register; nibbles fill in during RUN
//   Cout   out  carry out of bit 31
//   OF     out  two's-complement overflow
//   ZF     out  F == 0
//   busy   out  high while in RUN
//   done   out  one-cycle pulse once F and flags are final

module nibble_serial_adder32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        Cin,
`ifdef SUB_EN
    input  logic        Sub,
`endif
    output logic [31:0] F,
    output logic        Cout,
    output logic        OF,
    output logic        ZF,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  k;
    logic        carry;
    logic [31:0] x_r;
    logic [31:0] y_r;

    logic        accept;
    logic [31:0] y_eff;
    logic        c_init;
    logic [4:0]  nib_idx;
    logic [4:0]  nib_sum;
    logic [31:0] f_nxt;

    // A new operation may be launched from IDLE, or straight out of DONE
    // for back-to-back operation; requests during RUN are dropped.
    assign accept = start && (state != RUN);

    // Effective second operand and initial carry chosen at acceptance time.
    always_comb begin
        y_eff  = Y;
        c_init = Cin;
`ifdef SUB_EN
        if (Sub) begin
            y_eff  = ~Y;
            c_init = 1'b1;
        end
`endif
    end

    // Nibble adder for the current k, and F with that nibble replaced.
    always_comb begin
        nib_idx = {k, 2'b00};
        nib_sum = {1'b0, x_r[nib_idx +: 4]} + {1'b0, y_r[nib_idx +: 4]}
                + {4'b0000, carry};
        f_nxt   = F;
        f_nxt[nib_idx +: 4] = nib_sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (k == 3'd7) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= 3'd0;
            carry <= 1'b0;
            x_r   <= 32'h0;
            y_r   <= 32'h0;
            F     <= 32'h0;
            Cout  <= 1'b0;
            OF    <= 1'b0;
            ZF    <= 1'b0;
        end else if (accept) begin
            // F is left alone: its nibbles are overwritten one by one.
            x_r   <= X;
            y_r   <= y_eff;
            carry <= c_init;
            k     <= 3'd0;
        end else if (state == RUN) begin
            F     <= f_nxt;
            carry <= nib_sum[4];
            k     <= k + 3'd1;
            // Flags change only on the final nibble, from the completed result.
            if (k == 3'd7) begin
                Cout <= nib_sum[4];
                OF   <= (x_r[31] == y_r[31]) && (f_nxt[31] != x_r[31]);
                ZF   <= (f_nxt == 32'h0);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder32.sv
module tb_nibble_serial_adder32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic        Cin;
`ifdef SUB_EN
    logic        sub;
`endif
    logic [31:0] F;
    logic        Cout;
    logic        OF;
    logic        ZF;
    logic        busy;
    logic        done;

    nibble_serial_adder32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Cin   (Cin),
`ifdef SUB_EN
        .Sub   (sub),
`endif
        .F     (F),
        .Cout  (Cout),
        .OF    (OF),
        .ZF    (ZF),
        .busy  (busy),
        .done  (done)
    );

    typedef struct packed {
        logic [31:0] f;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_F",    F,              e.f);
                chk("sb_Cout", {31'b0, Cout},  {31'b0, e.c});
                chk("sb_OF",   {31'b0, OF},    {31'b0, e.o});
                chk("sb_ZF",   {31'b0, ZF},    {31'b0, e.z});
                chk("sb_busy", {31'b0, busy},  32'h0);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // One complete operation; operands are scrambled while busy to show
    // they are not re-sampled.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                          input logic s, input logic [31:0] ef, input logic ec,
                          input logic eo, input logic ez, input string nm);
        int n;
        int nb;
        sb.push_back('{ef, ec, eo, ez});
        X = x; Y = y; Cin = c;
`ifdef SUB_EN
        sub = s;
`else
        if (s) $display("note: %s needs SUB_EN", nm);
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            X = $urandom; Y = $urandom; Cin = 1'($urandom);
`ifdef SUB_EN
            sub = 1'($urandom);
`endif
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 8);
        chk({nm, "_busy_cycles"}, nb, 8);
        @(posedge clk); #1;
        chk({nm, "_done_one_cycle"}, {31'b0, done}, 32'h0);
    endtask

    initial begin
        int n;
        int d1;
        int d2;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0; Cin = 1'b0;
`ifdef SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_F",    F,              32'h0);
        chk("rst_Cout", {31'b0, Cout},  32'h0);
        chk("rst_OF",   {31'b0, OF},    32'h0);
        chk("rst_ZF",   {31'b0, ZF},    32'h0);
        chk("rst_busy", {31'b0, busy},  32'h0);
        chk("rst_done", {31'b0, done},  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ripple through all nibbles; a start at E3 must be ignored.
        sb.push_back('{32'h0, 1'b1, 1'b0, 1'b1});
        X = 32'hFFFF_FFFF; Y = 32'h0; Cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end  // E1, E2
        X = 32'h0000_0001; Y = 32'h0000_0002; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E3
        start = 1'b0;
        chk("ignored_start_busy", {31'b0, busy}, 32'h1);
        wait_done(n);
        chk("ignored_start_latency", n, 5);
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_F", F, 32'h0);
        chk("hold_idle", {31'b0, busy}, 32'h0);

        // Second run aborted by reset at E5; partial F visible, flags held.
        X = 32'h1234_5678; Y = 32'h1111_1111; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end  // E1..E4
        chk("partial_F", F, 32'h0000_6789);
        chk("flag_hold_Cout", {31'b0, Cout}, 32'h1);
        chk("flag_hold_ZF",   {31'b0, ZF},   32'h1);
        rst = 1'b1;
        @(posedge clk); #1;                       // E5
        rst = 1'b0;
        chk("abort_F",    F,             32'h0);
        chk("abort_Cout", {31'b0, Cout}, 32'h0);
        chk("abort_OF",   {31'b0, OF},   32'h0);
        chk("abort_ZF",   {31'b0, ZF},   32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        repeat (12) begin @(posedge clk); #1; end
        chk("abort_still_idle", {31'b0, busy}, 32'h0);

        // Directed vectors (carry from the ripple case must not leak into 1+2).
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0, "add_1_2");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "pos_ovf");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "wrap_zero");
        run_op(32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0, "cin_nib");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "neg_ovf");
`ifdef SUB_EN
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub_5_7");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
        run_op(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_eq");
        sub = 1'b0;
`endif

        // Back-to-back with start held through DONE.
        sb.push_back('{32'h2345_6789, 1'b0, 1'b0, 1'b0});
        sb.push_back('{32'h0000_0000, 1'b1, 1'b1, 1'b1});
        X = 32'h1234_5678; Y = 32'h1111_1111; Cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        chk("b2b_first_latency", n, 8);
        d1 = cyc;
        X = 32'h8000_0000; Y = 32'h8000_0000; Cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_no_idle", {31'b0, busy}, 32'h1);
        wait_done(n);
        chk("b2b_second_latency", n, 8);
        d2 = cyc;
        chk("b2b_spacing", d2 - d1, 9);
        repeat (2) begin @(posedge clk); #1; end

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder32.md
NIBBLE_SERIAL_ADDER32 -- requirements
Module: nibble_serial_adder32

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-002 The block SHALL have these data and control ports:
- start  input  1  request to begin an operation; sampled on clk rising edge
- X  input  32  first operand; sampled only when start is accepted
- Y  input  32  second operand; sampled only when start is accepted
- Cin  input  1  carry-in to bit 0; sampled only when start is accepted
- Sub  input  1  1 = subtract; present only with SUB_EN
- F  output  32  result register
- Cout  output  1  carry out of bit 31
- OF  output  1  two's-complement overflow
- ZF  output  1  1 when F == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when F and the flags are valid
REQ-003 The block SHALL have no parameters; the width is fixed at 32 bits, processed 4 bits per cycle.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-005 start SHALL be accepted in IDLE or DONE, and ignored while in RUN.
REQ-006 On acceptance, the block SHALL latch X, the effective Y (Yeff) and the carry, clear the 3-bit nibble counter k, and enter RUN.
REQ-007 Add mode (Sub=0, or SUB_EN undefined): Yeff = Y, and the initial carry = Cin.
REQ-008 In each RUN cycle, the internal 4-bit adder SHALL compute X[4k+3:4k] + Yeff[4k+3:4k] + carry.
- The sum SHALL be written to F[4k+3:4k].
- The nibble carry-out SHALL be stored as the new carry.
- k SHALL then be incremented.
REQ-009 RUN SHALL last exactly 8 cycles (k = 0..7). After the k = 7 update, the FSM SHALL enter DONE.
REQ-010 Latency: with start accepted at edge E0, the nibble updates SHALL occur at edges E1..E8, and done SHALL be 1 for exactly the cycle following E8.
REQ-011 In the DONE state, done SHALL be 1 and busy SHALL be 0. The next edge SHALL go to RUN if start=1, otherwise to IDLE.
REQ-012 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-013 The final carry after nibble 7 SHALL be latched into Cout.
REQ-014 OF SHALL be computed as (X[31] == Yeff[31]) AND (F[31] != X[31]).
REQ-015 ZF SHALL be (F == 32'h0).
REQ-016 Cout, OF and ZF SHALL be updated only on the DONE transition.
REQ-017 F and the flags SHALL hold their values until the next accepted start.
- Partial F nibbles SHALL be visible during RUN.
- Flags SHALL keep their previous values until done.
REQ-018 Carry SHALL propagate only between consecutive nibbles of the same operation; no carry SHALL leak between operations.
REQ-019 Input changes on X, Y, Cin or Sub while busy=1 SHALL have no effect.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL set state = IDLE, k = 0, carry = 0, F = 0, Cout = 0, OF = 0, ZF = 0, busy = 0, done = 0.
REQ-021 rst SHALL take priority over start. Asserting rst during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-022 With rst=0, the first accepted start after reset SHALL behave exactly as REQ-006..REQ-017.

Configuration
REQ-023 The macro SUB_EN SHALL control subtraction support.
- SUB_EN defined: the port Sub SHALL exist. Sub=1 at acceptance SHALL latch Yeff = ~Y and an initial carry of 1, with Cin ignored, so that F = X - Y.
- SUB_EN defined: Cout=1 SHALL mean no borrow.
- SUB_EN undefined: the Sub port SHALL be absent and the block SHALL be add-only.

Verification
REQ-024 X=32'h0000_0001, Y=32'h0000_0002, Cin=0, start at E0 -> busy=1 for E1..E8; done=1 for one cycle after E8; F=32'h0000_0003, Cout=0, OF=0, ZF=0.
REQ-025 X=32'hFFFF_FFFF, Y=32'h0000_0000, Cin=1 -> carry ripples through all 8 nibbles; F=32'h0, Cout=1, ZF=1, OF=0.
REQ-026 X=32'h7FFF_FFFF, Y=32'h0000_0001, Cin=0 -> F=32'h8000_0000, OF=1, Cout=0, ZF=0.
REQ-027 Start an operation, pulse start again at E3 with different operands, then assert rst at E5 of a second run -> the E3 start is ignored and the first result is unchanged; after rst, all outputs are 0, there is no done pulse, and the FSM is in IDLE.
REQ-028 start held at 1 through DONE -> back-to-back operations with no IDLE cycle; done pulses 9 cycles apart.
REQ-029 SUB_EN defined: X=32'h0000_0005, Y=32'h0000_0007, Sub=1 -> F=32'hFFFF_FFFE, Cout=0, OF=0; X=32'h8000_0000, Y=32'h0000_0001, Sub=1 -> F=32'h7FFF_FFFF, OF=1, Cout=1.
